// File: rtl/vc_dest_router.sv
// Purpose: strict-priority (VC0 first) popper of two VC FIFOs, steering each word to D0/D1 by DEST_BIT.
// Latency: 2 cycles from VC*_rd to D*_wr; sustains 1 word/cycle.
// Backpressure: either D*_almost_full stops pops at once (HOLD); up to 2 in-flight words still land.
module vc_dest_router #(
    parameter int BW       = 6,
    parameter int DEST_BIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             VC0_empty,
    input  logic             VC1_empty,
    input  logic [BW-1:0]    VC0_data_out,
    input  logic [BW-1:0]    VC1_data_out,
    input  logic             D0_almost_full,
    input  logic             D1_almost_full,
    input  logic             D0_full,
    input  logic             D1_full,
    output logic             VC0_rd,
    output logic             VC1_rd,
    output logic             D0_wr,
    output logic             D1_wr,
    output logic [BW-1:0]    D0_data_in,
    output logic [BW-1:0]    D1_data_in,
    output logic [CNT_W-1:0] D0_count,
    output logic [CNT_W-1:0] D1_count,
    output logic             router_error,
    output logic [1:0]       router_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        HOLD   = 2'b10
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            go;
    logic            s1_vld;
    logic            s1_src;
    logic [BW-1:0]   s1_word;
    logic            s1_dest;
    logic            s1_full;
    logic            wr0_nxt;
    logic            wr1_nxt;

    assign router_state = state;

    // Pop arbitration: both destinations gate pops since the target is unknown until the word is read.
    always_comb begin
        go     = reset_L && (state != HOLD) && !D0_almost_full && !D1_almost_full;
        VC0_rd = go && !VC0_empty;
        VC1_rd = go && VC0_empty && !VC1_empty;
    end

    // Stage 1: select the word popped last cycle, decode its destination and check that target's full flag.
    always_comb begin
        s1_word = s1_src ? VC1_data_out : VC0_data_out;
        s1_dest = s1_word[DEST_BIT];
        s1_full = s1_dest ? D1_full : D0_full;
        wr0_nxt = s1_vld && !s1_dest && !D0_full;
        wr1_nxt = s1_vld &&  s1_dest && !D1_full;
    end

    // Next-state logic; HOLD only releases once both almost-full flags drop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (go && (!VC0_empty || !VC1_empty))
                    state_nxt = ACTIVE;
            end
            ACTIVE: begin
                if (D0_almost_full || D1_almost_full)
                    state_nxt = HOLD;
                else if (VC0_empty && VC1_empty && !s1_vld)
                    state_nxt = IDLE;
            end
            HOLD: begin
                if (!D0_almost_full && !D1_almost_full)
                    state_nxt = (VC0_empty && VC1_empty) ? IDLE : ACTIVE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pipeline valid, stage-2 write registers, counters and sticky error.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state        <= IDLE;
            s1_vld       <= 1'b0;
            s1_src       <= 1'b0;
            D0_wr        <= 1'b0;
            D1_wr        <= 1'b0;
            D0_data_in   <= '0;
            D1_data_in   <= '0;
            D0_count     <= '0;
            D1_count     <= '0;
            router_error <= 1'b0;
        end else begin
            state  <= state_nxt;
            s1_vld <= VC0_rd || VC1_rd;
            s1_src <= VC1_rd;
            D0_wr  <= wr0_nxt;
            D1_wr  <= wr1_nxt;
            if (wr0_nxt) begin
                D0_data_in <= s1_word;
                D0_count   <= D0_count + CNT_W'(1);
            end
            if (wr1_nxt) begin
                D1_data_in <= s1_word;
                D1_count   <= D1_count + CNT_W'(1);
            end
            // A word aimed at a full destination is dropped, and the event is remembered until reset.
            if (s1_vld && s1_full)
                router_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vc_dest_router.sv
// Purpose: bench for vc_dest_router with queue-based VC FIFO models and a reference model.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: almost-full/full flags driven directly by the bench.
module tb_vc_dest_router;
    localparam int BW = 6;
    localparam int DEST_BIT = 4;
    localparam int CNT_W = 8;
    localparam int M_IDLE = 0, M_ACTIVE = 1, M_HOLD = 2;

    logic clk = 1'b0;
    logic reset_L;
    logic VC0_empty, VC1_empty;
    logic [BW-1:0] VC0_data_out, VC1_data_out;
    logic D0_almost_full, D1_almost_full, D0_full, D1_full;
    logic VC0_rd, VC1_rd, D0_wr, D1_wr;
    logic [BW-1:0] D0_data_in, D1_data_in;
    logic [CNT_W-1:0] D0_count, D1_count;
    logic router_error;
    logic [1:0] router_state;

    int errors = 0;
    int checks = 0;

    // VC FIFO contents
    logic [BW-1:0] q0[$];
    logic [BW-1:0] q1[$];

    // reference model state
    int            m_state = M_IDLE;
    bit            m_s1_vld = 0;
    logic [BW-1:0] m_s1_word = '0;
    bit            m_wr0 = 0, m_wr1 = 0, m_err = 0;
    logic [BW-1:0] m_d0 = '0, m_d1 = '0;
    int            m_c0 = 0, m_c1 = 0;
    bit            e_rd0, e_rd1;

    vc_dest_router #(.BW(BW), .DEST_BIT(DEST_BIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_L(reset_L),
        .VC0_empty(VC0_empty), .VC1_empty(VC1_empty),
        .VC0_data_out(VC0_data_out), .VC1_data_out(VC1_data_out),
        .D0_almost_full(D0_almost_full), .D1_almost_full(D1_almost_full),
        .D0_full(D0_full), .D1_full(D1_full),
        .VC0_rd(VC0_rd), .VC1_rd(VC1_rd),
        .D0_wr(D0_wr), .D1_wr(D1_wr),
        .D0_data_in(D0_data_in), .D1_data_in(D1_data_in),
        .D0_count(D0_count), .D1_count(D1_count),
        .router_error(router_error), .router_state(router_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic sync_empty();
        VC0_empty = (q0.size() == 0);
        VC1_empty = (q1.size() == 0);
    endtask

    // Expected pops this cycle: VC0 strictly first, nothing while held, backpressured or in reset.
    task automatic eval_comb();
        bit go;
        go = (reset_L === 1'b1) && (m_state != M_HOLD) && !D0_almost_full && !D1_almost_full;
        e_rd0 = go && (q0.size() > 0);
        e_rd1 = go && (q0.size() == 0) && (q1.size() > 0);
    endtask

    task automatic settle();
        sync_empty();
        #1;
        eval_comb();
    endtask

    // Advance one clock: model the router's effect of this cycle, then the FIFOs' read data.
    task automatic clk_step();
        bit r0, r1, dest, any;
        int n_state, n_c0, n_c1;
        bit n_s1, n_wr0, n_wr1, n_err;
        logic [BW-1:0] n_w, n_d0, n_d1;
        sync_empty();
        eval_comb();
        r0 = e_rd0; r1 = e_rd1;
        any = (q0.size() > 0) || (q1.size() > 0);
        n_state = m_state; n_wr0 = 0; n_wr1 = 0; n_err = m_err;
        n_d0 = m_d0; n_d1 = m_d1; n_c0 = m_c0; n_c1 = m_c1;
        n_s1 = r0 || r1;
        n_w = r0 ? q0[0] : (r1 ? q1[0] : '0);
        if (reset_L !== 1'b1) begin
            n_state = M_IDLE; n_s1 = 0; n_err = 0;
            n_d0 = '0; n_d1 = '0; n_c0 = 0; n_c1 = 0;
        end else begin
            if (m_s1_vld) begin
                dest = m_s1_word[DEST_BIT];
                if (dest ? D1_full : D0_full) n_err = 1;
                else if (dest) begin n_wr1 = 1; n_d1 = m_s1_word; n_c1 = (m_c1 + 1) % (1 << CNT_W); end
                else begin n_wr0 = 1; n_d0 = m_s1_word; n_c0 = (m_c0 + 1) % (1 << CNT_W); end
            end
            case (m_state)
                M_IDLE:   if ((r0 || r1) && any) n_state = M_ACTIVE;
                M_ACTIVE: if (D0_almost_full || D1_almost_full) n_state = M_HOLD;
                          else if (!any && !m_s1_vld) n_state = M_IDLE;
                M_HOLD:   if (!D0_almost_full && !D1_almost_full) n_state = any ? M_ACTIVE : M_IDLE;
                default:  n_state = M_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
        if (r0) VC0_data_out = q0.pop_front();
        if (r1) VC1_data_out = q1.pop_front();
        m_state = n_state; m_s1_vld = n_s1; m_s1_word = n_w;
        m_wr0 = n_wr0; m_wr1 = n_wr1; m_err = n_err;
        m_d0 = n_d0; m_d1 = n_d1; m_c0 = n_c0; m_c1 = n_c1;
        sync_empty();
    endtask

    task automatic apply_reset();
        reset_L = 1'b0;
        q0.delete(); q1.delete();
        D0_almost_full = 0; D1_almost_full = 0; D0_full = 0; D1_full = 0;
        VC0_data_out = '0; VC1_data_out = '0;
        clk_step();
        clk_step();
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        q0.delete(); q1.delete();
        D0_almost_full = 0; D1_almost_full = 0; D0_full = 0; D1_full = 0;
        VC0_data_out = '0; VC1_data_out = '0;
        q0.push_back(6'h15);
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++; if (VC0_rd !== 1'b0) begin errors++; $display("FAIL reset_rd: VC0_rd=%0b want 0", VC0_rd); end
            clk_step();
        end
        settle();
        checks++; if ({D0_wr, D1_wr} !== 2'b00) begin errors++; $display("FAIL reset_wr: got %b want 00", {D0_wr, D1_wr}); end
        checks++; if ({D0_count, D1_count} !== '0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", D0_count, D1_count); end
        checks++; if (router_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", router_state); end
        checks++; if (router_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", router_error); end
        reset_L = 1'b1;
        settle();
        checks++; if (VC0_rd !== 1'b1) begin errors++; $display("FAIL reset_first_pop: VC0_rd=%0b want 1", VC0_rd); end
        clk_step();
        clk_step();
        settle();
        checks++; if (D1_wr !== 1'b1 || D1_data_in !== 6'h15) begin errors++; $display("FAIL reset_first_wr: D1_wr=%0b data=%0h want 1/15", D1_wr, D1_data_in); end
        checks++; if (D1_count !== 8'd1) begin errors++; $display("FAIL reset_first_cnt: D1_count=%0d want 1", D1_count); end
    endtask

    task automatic test_priority();
        apply_reset();
        q0.push_back(6'h03); q0.push_back(6'h13); q1.push_back(6'h01);
        for (int i = 0; i < 6; i++) begin
            settle();
            checks++; if ({VC0_rd, VC1_rd} !== {1'(i < 2), 1'(i == 2)}) begin errors++; $display("FAIL prio_rd[%0d]: got %b want %b", i, {VC0_rd, VC1_rd}, {1'(i < 2), 1'(i == 2)}); end
            checks++; if ({D0_wr, D1_wr} !== {1'(i == 2 || i == 4), 1'(i == 3)}) begin errors++; $display("FAIL prio_wr[%0d]: got %b", i, {D0_wr, D1_wr}); end
            if (i == 2) begin checks++; if (D0_data_in !== 6'h03) begin errors++; $display("FAIL prio_d0a: got %0h want 03", D0_data_in); end end
            if (i == 3) begin checks++; if (D1_data_in !== 6'h13) begin errors++; $display("FAIL prio_d1: got %0h want 13", D1_data_in); end end
            if (i == 4) begin checks++; if (D0_data_in !== 6'h01) begin errors++; $display("FAIL prio_d0b: got %0h want 01", D0_data_in); end end
            clk_step();
        end
        settle();
        checks++; if (D0_count !== 8'd2 || D1_count !== 8'd1) begin errors++; $display("FAIL prio_cnt: got %0d/%0d want 2/1", D0_count, D1_count); end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int k = 1; k <= 6; k++) q0.push_back(6'(k));
        for (int i = 0; i < 16; i++) begin
            D0_almost_full = (i >= 2 && i <= 5);
            settle();
            checks++; if (VC0_rd !== 1'((i < 2) || (i >= 7 && i <= 10))) begin errors++; $display("FAIL bp_rd[%0d]: got %b", i, VC0_rd); end
            if (i >= 3 && i <= 6) begin checks++; if (router_state !== 2'b10) begin errors++; $display("FAIL bp_hold[%0d]: got %b want 10", i, router_state); end end
            if (i == 7) begin checks++; if (router_state !== 2'b01) begin errors++; $display("FAIL bp_resume: got %b want 01", router_state); end end
            checks++; if (D0_wr !== 1'(i == 2 || i == 3 || (i >= 9 && i <= 12))) begin errors++; $display("FAIL bp_wr[%0d]: got %b", i, D0_wr); end
            if (i == 3) begin checks++; if (D0_data_in !== 6'h02) begin errors++; $display("FAIL bp_inflight: got %0h want 02", D0_data_in); end end
            clk_step();
        end
        settle();
        checks++; if (D0_count !== 8'd6 || D0_data_in !== 6'h06) begin errors++; $display("FAIL bp_done: cnt=%0d data=%0h want 6/06", D0_count, D0_data_in); end
    endtask

    task automatic test_full_error();
        apply_reset();
        q0.push_back(6'h1F);
        settle();
        clk_step();
        D1_full = 1'b1;
        settle();
        clk_step();
        D1_full = 1'b0;
        settle();
        checks++; if (D1_wr !== 1'b0) begin errors++; $display("FAIL full_wr: D1_wr=%0b want 0", D1_wr); end
        checks++; if (router_error !== 1'b1) begin errors++; $display("FAIL full_err: got %0b want 1", router_error); end
        checks++; if (D1_count !== 8'd0) begin errors++; $display("FAIL full_cnt: got %0d want 0", D1_count); end
        q0.push_back(6'h11); q0.push_back(6'h02);
        for (int i = 0; i < 6; i++) begin settle(); clk_step(); end
        settle();
        checks++; if (router_error !== 1'b1) begin errors++; $display("FAIL full_sticky: got %0b want 1", router_error); end
        checks++; if (D1_count !== 8'd1 || D0_count !== 8'd1) begin errors++; $display("FAIL full_after: got %0d/%0d want 1/1", D0_count, D1_count); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        q0.push_back(6'h07); q0.push_back(6'h12);
        settle(); clk_step();
        settle(); clk_step();
        settle();
        checks++; if (D0_wr !== 1'b1 || D0_count !== 8'd1) begin errors++; $display("FAIL mid_pre: wr=%0b cnt=%0d want 1/1", D0_wr, D0_count); end
        reset_L = 1'b0;
        settle();
        checks++; if ({VC0_rd, VC1_rd} !== 2'b00) begin errors++; $display("FAIL mid_rd: got %b want 00", {VC0_rd, VC1_rd}); end
        clk_step();
        reset_L = 1'b1;
        settle();
        checks++; if ({D0_wr, D1_wr, router_error, router_state} !== 5'b0) begin errors++; $display("FAIL mid_ctl: got %b want 0", {D0_wr, D1_wr, router_error, router_state}); end
        checks++; if ({D0_data_in, D1_data_in, D0_count, D1_count} !== '0) begin errors++; $display("FAIL mid_dat: got %0h/%0h/%0d/%0d want 0", D0_data_in, D1_data_in, D0_count, D1_count); end
        for (int i = 0; i < 4; i++) begin
            settle();
            checks++; if (D1_wr !== 1'b0) begin errors++; $display("FAIL mid_ghost[%0d]: D1_wr=%0b want 0", i, D1_wr); end
            clk_step();
        end
        q0.push_back(6'h05);
        for (int i = 0; i < 4; i++) begin settle(); clk_step(); end
        settle();
        checks++; if (D0_count !== 8'd1 || D0_data_in !== 6'h05 || D1_count !== 8'd0) begin errors++; $display("FAIL mid_resume: cnt=%0d data=%0h d1=%0d want 1/05/0", D0_count, D0_data_in, D1_count); end
    endtask

    task automatic test_wrap();
        int n = 0, pops = 0;
        apply_reset();
        for (int k = 0; k < 257; k++) q0.push_back(6'($urandom_range(0, 63)) & 6'h2F);
        while (q0.size() > 0 && n < 400) begin
            settle();
            if (VC0_rd === 1'b1) pops++;
            clk_step();
            n++;
        end
        for (int i = 0; i < 3; i++) begin settle(); clk_step(); end
        settle();
        checks++; if (pops != 257 || n != 257) begin errors++; $display("FAIL wrap_rate: pops=%0d cycles=%0d want 257/257", pops, n); end
        checks++; if (D0_count !== 8'd1) begin errors++; $display("FAIL wrap_cnt: got %0d want 1", D0_count); end
        checks++; if (router_error !== 1'b0 || D1_count !== 8'd0) begin errors++; $display("FAIL wrap_clean: err=%0b d1=%0d want 0/0", router_error, D1_count); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) q0.push_back(6'($urandom));
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) q1.push_back(6'($urandom));
            D0_almost_full = ($urandom_range(0, 9) == 0);
            D1_almost_full = ($urandom_range(0, 9) == 0);
            D0_full = ($urandom_range(0, 39) == 0);
            D1_full = ($urandom_range(0, 39) == 0);
            reset_L = ($urandom_range(0, 299) != 0);
            settle();
            checks++; if ({VC0_rd, VC1_rd} !== {e_rd0, e_rd1}) begin errors++; $display("FAIL rnd_rd[%0d]: got %b want %b", i, {VC0_rd, VC1_rd}, {e_rd0, e_rd1}); end
            checks++; if ({D0_wr, D1_wr} !== {m_wr0, m_wr1}) begin errors++; $display("FAIL rnd_wr[%0d]: got %b want %b", i, {D0_wr, D1_wr}, {m_wr0, m_wr1}); end
            checks++; if (D0_data_in !== m_d0 || D1_data_in !== m_d1) begin errors++; $display("FAIL rnd_data[%0d]: got %0h/%0h want %0h/%0h", i, D0_data_in, D1_data_in, m_d0, m_d1); end
            checks++; if (D0_count !== CNT_W'(m_c0) || D1_count !== CNT_W'(m_c1)) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, D0_count, D1_count, m_c0, m_c1); end
            checks++; if (router_error !== m_err) begin errors++; $display("FAIL rnd_err[%0d]: got %0b want %0b", i, router_error, m_err); end
            checks++; if (router_state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state[%0d]: got %b want %0d", i, router_state, m_state); end
            clk_step();
        end
    endtask

    initial begin
        reset_L = 1'b0;
        VC0_empty = 1'b1; VC1_empty = 1'b1;
        VC0_data_out = '0; VC1_data_out = '0;
        D0_almost_full = 0; D1_almost_full = 0; D0_full = 0; D1_full = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_priority();
        test_backpressure();
        test_full_error();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vc_dest_router.md
Name: vc_dest_router

Overview:
Upstream feeder for the destination FIFOs D0 and D1. It pops words from two virtual-channel FIFOs, VC0 and VC1, using strict priority with VC0 first. Each word is steered to D0 or D1 according to a destination bit in the word. The block honours the D0/D1 almost-full backpressure, counts the words delivered to each destination, and flags any write attempted into a full destination.

Parameters:
BW, 6, data word width (matches D0/D1/VC FIFO width)
DEST_BIT, 4, bit index of word selecting destination (0 = D0, 1 = D1); must be < BW
CNT_W, 8, width of per-destination delivered-word counters

Ports:
clk  input  1  clock
reset_L  input  1  synchronous active-low reset
VC0_empty  input  1  VC0 FIFO empty
VC1_empty  input  1  VC1 FIFO empty
VC0_data_out  input  BW  VC0 read data, valid the cycle after VC0_rd
VC1_data_out  input  BW  VC1 read data, valid the cycle after VC1_rd
D0_almost_full  input  1  D0 backpressure
D1_almost_full  input  1  D1 backpressure
D0_full  input  1  D0 full
D1_full  input  1  D1 full
VC0_rd  output  1  pop VC0 (combinational)
VC1_rd  output  1  pop VC1 (combinational)
D0_wr  output  1  push D0 (registered)
D1_wr  output  1  push D1 (registered)
D0_data_in  output  BW  data to D0 (registered)
D1_data_in  output  BW  data to D1 (registered)
D0_count  output  CNT_W  words written to D0, wraps
D1_count  output  CNT_W  words written to D1, wraps
router_error  output  1  sticky: write attempted into full destination
router_state  output  2  current FSM state (debug)

Behaviour:
- Reset, sampled on clk rising edge while reset_L=0:
  - all registered outputs go to 0: D*_wr, D*_data_in, D*_count, router_error.
  - in-flight pipeline valid is cleared.
  - state goes to IDLE (2'b00).
  - VC*_rd forced to 0 while reset_L=0.
  - Reset mid-transfer discards the in-flight word; no write is issued for it.
- Pop-enable condition: go = state!=HOLD and !D0_almost_full and !D1_almost_full. Both destinations are gated because the destination is unknown before the read.
- Arbitration, evaluated each cycle:
  - VC0_rd = go & !VC0_empty.
  - VC1_rd = go & VC0_empty & !VC1_empty.
  - At most one rd is high per cycle.
- Pipeline stage 1, cycle N+1 after a pop in cycle N:
  - the registered source select picks the VC*_data_out word.
  - the word's DEST_BIT is decoded.
- Pipeline stage 2, registered at the end of N+1 and visible in N+2:
  - exactly one of D0_wr/D1_wr is high.
  - the word is placed on the matching D*_data_in; the other data bus holds its previous value.
- Pop-to-write latency is 2 cycles. Sustained throughput is 1 word/cycle.
- Up to 2 words can be in flight after almost_full rises. Destination FIFO almost-full margin (TOL) must be ≥2.
- FSM states:
  - IDLE (00): nothing popped. → ACTIVE when go & any VC non-empty.
  - ACTIVE (01): popping. → HOLD when either D*_almost_full=1. → IDLE when both VCs are empty and no word is in flight.
  - HOLD (10): no pops; in-flight words still complete. → ACTIVE when both almost_full=0 and a VC is non-empty. → IDLE when both almost_full=0 and both VCs are empty.
  - Encoding 11 is unused and goes to IDLE.
- Full check: D0_full/D1_full are sampled in the stage-1 cycle. If the target is full:
  - the write is suppressed.
  - router_error is set and stays set until reset.
  - the word is dropped and not counted.
- Counters: D*_count increments by 1 in the cycle the corresponding D*_wr is registered high; wraps 2^CNT_W-1 → 0.
- If both VCs go non-empty in the same cycle, VC0 wins. VC1 starves while VC0 stays non-empty, by design.
- An empty flag toggling in the same cycle as a pop is the FIFO's concern. The router trusts the current-cycle empty flag.

Test Plan:
1. Reset with VC0 non-empty, data 6'h15 → no rd, no wr, counts 0, state 00; after release, VC0_rd at cycle 1, D1_wr=1 with D1_data_in=6'h15 at cycle 3 (bit4=1), D1_count=1.
2. VC0 holds {6'h03, 6'h13}, VC1 holds {6'h01} → pops VC0, VC0, VC1 on consecutive cycles; writes D0(03), D1(13), D0(01) on consecutive cycles; D0_count=2, D1_count=1.
3. Stream of 6 D0-words, D0_almost_full asserted after 2nd pop → rd stops same cycle, state=HOLD, 2 in-flight words still written; almost_full drops → state=ACTIVE, remaining 4 delivered, D0_count=6.
4. D1_full=1 while a D1-bound word (6'h1F) is in stage 1 → D1_wr stays 0, router_error=1 and stays 1 through later traffic, D1_count unchanged.
5. reset_L=0 in cycle after a pop → no write ever issued for that word; all outputs 0 next cycle; operation resumes cleanly after release.
6. CNT_W=8: deliver 257 D0-words → D0_count=1 (wrap verified), router_error=0.
